vga_line_fetcher: RTL and testbench

//  Stage upstream of the VGA pixel output path. Prefetches one 8-bit RGB332 frame-buffer line per

---
 rtl/vga_line_fetcher_if.sv | 19 +
 rtl/vga_line_fetcher.sv | 119 +++++++++++
 tb/tb_vga_line_fetcher.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_fetcher_if.sv
// Pipelined Avalon-MM read bus between the line fetcher (master) and the frame-buffer memory (slave).
// The master holds address and read stable while waitrequest is high; readdatavalid returns data in order.
interface vga_line_fetcher_if;
   logic [31:0] address;
   logic        read;
   logic        waitrequest;
   logic        readdatavalid;
   logic [31:0] readdata;

   modport master (
      output address, read,
      input  waitrequest, readdatavalid, readdata
   );

   modport slave (
      input  address, read,
      output waitrequest, readdatavalid, readdata
   );
endinterface

// File: rtl/vga_line_fetcher.sv
// Prefetches one RGB332 line per request into a ping-pong buffer and serves pixels with 1-cycle latency.
// Memory stalls only slow the fetch (at most MAX_PENDING reads in flight); the pixel side never stalls.
module vga_line_fetcher #(
   parameter int LINE_PIXELS = 320,
   parameter int MAX_PENDING = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] frame_base,
   input  logic        fetch_en,
   input  logic        line_req,
   input  logic [8:0]  line_row,
   input  logic        clr_underrun,
   vga_line_fetcher_if.master master,
   input  logic        pix_rd,
   input  logic [8:0]  pix_col,
   output logic [7:0]  pix_data,
   output logic        busy,
   output logic        underrun
);
   localparam int LINE_WORDS = LINE_PIXELS / 4;
   localparam int CNT_W      = $clog2(LINE_WORDS + 1);
   localparam int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int PEND_W     = 4;
   localparam logic [9:0] PIX_LIM = 10'(LINE_PIXELS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   issue_cnt, rx_cnt;
   logic [PEND_W-1:0]  pending;
   logic [31:0]        addr_r;
   logic               wr_bank, rd_bank;
   logic [31:0]        line_buf [2][LINE_WORDS];
   logic               start, rd_en, accept, rx_vld, last_issue, last_rx;
   logic [IDX_W-1:0]   pix_word;
   logic [31:0]        rd_word;

   assign start      = line_req && fetch_en && (state == IDLE);
   assign rd_en      = (state == ISSUE) && (pending < PEND_W'(MAX_PENDING));
   assign accept     = rd_en && !master.waitrequest;
   // Returns arriving while idle belong to an aborted fetch and are dropped.
   assign rx_vld     = master.readdatavalid && (state != IDLE);
   assign last_issue = (issue_cnt == CNT_W'(LINE_WORDS - 1));
   assign last_rx    = rx_vld && (rx_cnt == CNT_W'(LINE_WORDS - 1));

   assign master.read    = rd_en;
   assign master.address = addr_r;
   assign busy           = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (accept && last_issue) state_nxt = DRAIN;
         DRAIN:   if (last_rx) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_r    <= '0;
         issue_cnt <= '0;
         rx_cnt    <= '0;
         pending   <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b1;
         underrun  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            rd_bank   <= wr_bank;
            wr_bank   <= ~wr_bank;
            addr_r    <= frame_base + 32'(line_row) * 32'(LINE_PIXELS);
            issue_cnt <= '0;
            rx_cnt    <= '0;
         end else begin
            if (accept) begin
               issue_cnt <= issue_cnt + 1'b1;
               addr_r    <= addr_r + 32'd4;
            end
            if (rx_vld) rx_cnt <= rx_cnt + 1'b1;
         end
         case ({accept, rx_vld})
            2'b10:   pending <= pending + 1'b1;
            2'b01:   pending <= pending - 1'b1;
            default: pending <= pending;
         endcase
         // A late request is flagged and dropped; set beats a simultaneous clear.
         if (line_req && busy)  underrun <= 1'b1;
         else if (clr_underrun) underrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rx_vld && (rx_cnt < CNT_W'(LINE_WORDS)))
         line_buf[wr_bank][rx_cnt[IDX_W-1:0]] <= master.readdata;
   end

   assign pix_word = IDX_W'(pix_col >> 2);
   assign rd_word  = line_buf[rd_bank][pix_word];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_data <= 8'h00;
      end else if (pix_rd && ({1'b0, pix_col} < PIX_LIM)) begin
         case (pix_col[1:0])
            2'd0:    pix_data <= rd_word[31:24];
            2'd1:    pix_data <= rd_word[23:16];
            2'd2:    pix_data <= rd_word[15:8];
            default: pix_data <= rd_word[7:0];
         endcase
      end else begin
         pix_data <= 8'h00;
      end
   end
endmodule

// File: tb/tb_vga_line_fetcher.sv
// Randomized bench: an Avalon memory model feeds the fetcher; a line-level reference model predicts
// addresses, busy/underrun and pixels, and a negedge monitor compares them against the DUT.
module tb_vga_line_fetcher;
   localparam int LP   = 320;
   localparam int LW   = LP / 4;
   localparam int MAXP = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] frame_base;
   logic        fetch_en, line_req, clr_underrun;
   logic [8:0]  line_row;
   logic        pix_rd;
   logic [8:0]  pix_col;
   logic [7:0]  pix_data;
   logic        busy, underrun;

   vga_line_fetcher_if bus();

   vga_line_fetcher #(.LINE_PIXELS(LP), .MAX_PENDING(MAXP)) dut (
      .clk(clk), .reset_n(reset_n), .frame_base(frame_base), .fetch_en(fetch_en),
      .line_req(line_req), .line_row(line_row), .clr_underrun(clr_underrun),
      .master(bus), .pix_rd(pix_rd), .pix_col(pix_col), .pix_data(pix_data),
      .busy(busy), .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   int unsigned mem_salt;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1280) return 32'h1122_3344;
      return (a * 32'h9E37_79B1) ^ mem_salt;
   endfunction

   // ---------------- memory model (Avalon slave) ----------------
   typedef struct { logic [31:0] d; int due; } rsp_t;
   rsp_t pipe[$];
   int   lat = 3, wait_pct = 0, gap_pct = 0;
   bit   stall_all = 0;

   initial begin
      logic        m_acc;
      logic [31:0] m_a;
      rsp_t        r;
      bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0;
      forever begin
         @(negedge clk);
         m_acc = reset_n && bus.read && !bus.waitrequest;
         m_a   = bus.address;
         @(posedge clk); #1;
         if (!reset_n) begin
            pipe.delete();
            bus.readdatavalid = 1'b0;
            bus.waitrequest   = 1'b0;
         end else begin
            if (m_acc) begin
               r.d = mem_word(m_a); r.due = cyc + lat - 1;
               pipe.push_back(r);
            end
            if (pipe.size() > 0 && pipe[0].due <= cyc && int'($urandom_range(99)) >= gap_pct) begin
               r = pipe.pop_front();
               bus.readdatavalid = 1'b1;
               bus.readdata      = r.d;
            end else begin
               bus.readdatavalid = 1'b0;
               bus.readdata      = $urandom;
            end
            bus.waitrequest = stall_all || (int'($urandom_range(99)) < wait_pct);
         end
      end
   end

   // ---------------- reference model + scoreboard monitor ----------------
   logic [31:0] addr_q[$];
   typedef struct { logic [7:0] v; int c; } pexp_t;
   pexp_t       pq[$];
   bit          m_busy, m_und, m_shown_vld, m_inprog_vld;
   logic [31:0] m_shown, m_inprog;
   int          rx_n, outst;
   bit          acc, rv, old_busy, prev_stall;
   logic [31:0] prev_addr;
   pexp_t       pe;

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_read", bus.read, 0);
         chk("rst_address", bus.address, 0);
         chk("rst_pix_data", pix_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_underrun", underrun, 0);
         addr_q.delete(); pq.delete();
         m_busy = 0; m_und = 0; m_shown_vld = 0; m_inprog_vld = 0;
         rx_n = 0; outst = 0; prev_stall = 0;
      end else begin
         acc = bus.read && !bus.waitrequest;
         rv  = bus.readdatavalid && m_busy;
         chk("busy", busy, m_busy);
         chk("underrun", underrun, m_und);
         if (prev_stall) begin
            chk("stall_read_held", bus.read, 1);
            chk("stall_addr_held", bus.address, prev_addr);
         end
         if (acc) begin
            if (addr_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_accept: got read at %h, expected no read", bus.address);
            end else begin
               chk("read_address", bus.address, addr_q.pop_front());
            end
         end
         outst = outst + int'(acc) - int'(rv);
         if (acc) chk("pending_le_max", outst <= MAXP, 1);
         prev_stall = bus.read && bus.waitrequest;
         prev_addr  = bus.address;
         if (pq.size() > 0 && pq[0].c == cyc - 1) begin
            pe = pq.pop_front();
            chk("pix_data", pix_data, pe.v);
         end
         // model state update for this cycle's events
         old_busy = m_busy;
         if (rv) begin
            rx_n++;
            if (rx_n == LW) m_busy = 0;
         end
         if (line_req && old_busy)  m_und = 1;
         else if (clr_underrun)     m_und = 0;
         if (line_req && !old_busy && fetch_en) begin
            m_busy = 1; rx_n = 0;
            m_shown = m_inprog; m_shown_vld = m_inprog_vld;
            m_inprog = frame_base + 32'(line_row) * LP; m_inprog_vld = 1;
            for (int i = 0; i < LW; i++) addr_q.push_back(m_inprog + 32'(4 * i));
         end
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [7:0] exp_pix(input bit rd, input int col);
      logic [31:0] w;
      if (!rd || col >= LP) return 8'h00;
      w = mem_word(m_shown + 32'(4 * (col / 4)));
      return 8'((w >> (8 * (3 - col % 4))) & 32'hFF);
   endfunction

   task automatic pix(input bit rd, input int col);
      pexp_t p;
      @(posedge clk); #1;
      pix_rd = rd; pix_col = 9'(col);
      if (m_shown_vld) begin
         p.v = exp_pix(rd, col); p.c = cyc;
         pq.push_back(p);
      end
   endtask

   task automatic pix_rand(input int n);
      for (int i = 0; i < n; i++) pix($urandom_range(9) != 0, int'($urandom_range(335)));
      @(posedge clk); #1 pix_rd = 0;
   endtask

   task automatic req(input logic [31:0] base, input logic [8:0] row, input bit en, input bit clr = 0);
      @(posedge clk); #1;
      frame_base = base; line_row = row; fetch_en = en; line_req = 1; clr_underrun = clr;
      @(posedge clk); #1;
      line_req = 0; clr_underrun = 0; frame_base = $urandom; line_row = 9'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (m_busy && n < budget) begin @(posedge clk); n++; end
      if (m_busy) begin
         n_cmp++; n_bad++;
         $display("FAIL fetch_timeout: still busy after %0d cycles, expected idle", budget);
      end
      repeat (2) @(posedge clk);
      #1 chk("all_reads_issued", addr_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; frame_base = '0; fetch_en = 0; line_req = 0; line_row = '0;
      clr_underrun = 0; pix_rd = 0; pix_col = '0;
      mem_salt = $urandom;
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
      chk("rst_wr_bank", dut.wr_bank, 0);
      chk("rst_rd_bank", dut.rd_bank, 1);

      // reset while stuck in ISSUE
      stall_all = 1;
      req(32'h1000, 9'd2, 1);
      repeat (4) @(posedge clk);
      #1 chk("issue_read_high", bus.read, 1);
      chk("swapped_wr_bank", dut.wr_bank, 1);
      reset_n = 0;
      #1;
      chk("midrst_read", bus.read, 0);
      chk("midrst_address", bus.address, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_wr_bank", dut.wr_bank, 0);
      chk("midrst_rd_bank", dut.rd_bank, 1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1; stall_all = 0;

      // zero-wait memory, latency 3
      lat = 3; wait_pct = 0; gap_pct = 0;
      req(32'h1000, 9'd2, 1);
      wait_idle(2000);

      // second request exposes the first line
      lat = 2; wait_pct = 30; gap_pct = 20;
      req(32'h1000, 9'd5, 1);
      for (int c = 0; c < 4; c++) pix(1, c);
      pix(1, 320);
      pix(0, 0);
      pix(1, 511);
      pix(1, 319);
      pix_rand(40);
      wait_idle(5000);

      // random lines under heavy stalls
      for (int it = 0; it < 6; it++) begin
         lat = int'($urandom_range(1, 6)); wait_pct = 50; gap_pct = int'($urandom_range(0, 60));
         req((it == 0) ? 32'hFFFF_FF00 : 32'($urandom), 9'($urandom), 1);
         if (it == 5) begin
            for (int c = 0; c < LP; c++) pix(1, c);
            @(posedge clk); #1 pix_rd = 0;
         end else begin
            pix_rand(100);
         end
         wait_idle(20000);
      end

      // overlapping requests: underrun, no swap, set beats clear
      lat = 4; wait_pct = 0; gap_pct = 0;
      req(32'h0004_0000, 9'd7, 1);
      repeat (10) @(posedge clk);
      req(32'h0008_0000, 9'd9, 1);
      repeat (3) @(posedge clk);
      req(32'h000C_0000, 9'd11, 1, 1);
      wait_idle(5000);
      @(posedge clk); #1 clr_underrun = 1;
      @(posedge clk); #1 clr_underrun = 0;
      req(32'h0010_0000, 9'd13, 1);
      pix_rand(60);
      wait_idle(5000);

      // fetch_en low: request ignored, displayed line unchanged
      req(32'h0020_0000, 9'd1, 0);
      repeat (20) @(posedge clk);
      pix_rand(40);
      // fetch_en dropping mid-fetch lets the current line finish
      req(32'h0030_0000, 9'd3, 1);
      repeat (5) @(posedge clk);
      #1 fetch_en = 0;
      wait_idle(5000);
      req(32'h0040_0000, 9'd4, 0);
      repeat (20) @(posedge clk);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
